// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl -- SPI mode-0 master that sends a 24-bit command header
// {status[3:0], addr[19:0]}, then writes or reads one word or a burst of
// 16-bit words.
//
// Parameters
//   CLK_DIV  : SCLK half-period in clk cycles (>= 1)
//   READ_GAP : clk cycles of idle SCLK inserted before every read word (>= 1)
//   CS_IDLE  : minimum clk cycles cs_n stays high between frames
//
// Ports
//   clk, reset            : single rising-edge clock, synchronous active-high reset
//   start                 : command request, sampled only while idle
//   cmd_status[3:0]       : bit2 write/read, bit1 burst/single, bit0 icn/rm, bit3 reserved
//   cmd_addr[19:0]        : target address
//   burst_len[7:0]        : burst word count minus one (burst commands only)
//   wr_data/wr_valid      : write word offered by the host
//   wr_ready              : one-cycle pulse when the offered write word is taken
//   rd_data/rd_valid      : received read word and its one-cycle qualifier
//   busy, done, cmd_err   : frame in progress, frame-finished pulse, bad-command pulse
//   sclk, mosi, cs_n, miso: SPI bus (mode 0)
module spi_master_ctrl #(
    parameter int CLK_DIV  = 2,
    parameter int READ_GAP = 16,
    parameter int CS_IDLE  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  cmd_status,
    input  logic [19:0] cmd_addr,
    input  logic [7:0]  burst_len,
    input  logic [15:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic        cmd_err,
    output logic        sclk,
    output logic        mosi,
    output logic        cs_n,
    input  logic        miso
);

    typedef enum logic [2:0] {
        IDLE, CS_SETUP, HEADER, WR_WAIT, WR_SHIFT, RD_GAP, RD_SHIFT, CS_HOLD
    } state_t;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF       = CNT_W'(CLK_DIV);          // first SCLK-high cycle
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(2 * CLK_DIV - 1);  // last cycle of a bit
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(READ_GAP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CLK_DIV + CS_IDLE - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;        // clk cycles within the current bit or phase
    logic [4:0]         bit_q, bit_d;        // bit index within header or word
    logic [8:0]         words_q, words_d;    // words left; 9 bits so 256 does not wrap
    logic [23:0]        shift_q, shift_d;    // outgoing bits, MSB is on mosi
    logic [15:0]        rx_q, rx_d;
    logic               is_write_q, is_write_d;
    logic [15:0]        rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               done_q, done_d;
    logic               cmd_err_q, cmd_err_d;

    logic bit_end;
    logic at_rise;
    logic shifting;

    assign bit_end  = (cnt_q == BIT_LAST);
    assign at_rise  = (cnt_q == HALF);
    assign shifting = (state_q == HEADER) || (state_q == WR_SHIFT) || (state_q == RD_SHIFT);

    // State register. Reset returns to IDLE on the next edge, which raises
    // cs_n immediately and drops any pending done/rd_valid of an aborted frame.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            words_q    <= '0;
            shift_q    <= '0;
            rx_q       <= '0;
            is_write_q <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            words_q    <= words_d;
            shift_q    <= shift_d;
            rx_q       <= rx_d;
            is_write_q <= is_write_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        // NOTE: every _d is defaulted first so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        words_d    = words_q;
        shift_d    = shift_q;
        rx_d       = rx_q;
        is_write_d = is_write_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        cmd_err_d  = 1'b0;

        // One bit = CLK_DIV cycles low then CLK_DIV cycles high.
        if (shifting) begin
            cnt_d = bit_end ? '0 : cnt_q + 16'd1;
        end

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (start) begin
                    if (cmd_status[3]) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        state_d    = CS_SETUP;
                        shift_d    = {cmd_status, cmd_addr};
                        is_write_d = cmd_status[2];
                        words_d    = cmd_status[1] ? {1'b0, burst_len} + 9'd1 : 9'd1;
                    end
                end
            end
            CS_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = HEADER;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            HEADER: begin
                if (bit_end) begin
                    shift_d = {shift_q[22:0], 1'b0};
                    bit_d   = bit_q + 5'd1;
                    if (bit_q == 5'd23) begin
                        bit_d   = '0;
                        state_d = is_write_q ? WR_WAIT : RD_GAP;
                    end
                end
            end
            WR_WAIT: begin
                cnt_d = '0;
                if (wr_valid) begin
                    shift_d = {wr_data, 8'h00};
                    bit_d   = '0;
                    state_d = WR_SHIFT;
                end
            end
            WR_SHIFT: begin
                if (bit_end) begin
                    shift_d = {shift_q[22:0], 1'b0};
                    bit_d   = bit_q + 5'd1;
                    if (bit_q == 5'd15) begin
                        bit_d   = '0;
                        words_d = words_q - 9'd1;
                        state_d = (words_q == 9'd1) ? CS_HOLD : WR_WAIT;
                    end
                end
            end
            RD_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = RD_SHIFT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RD_SHIFT: begin
                // miso is taken on the cycle SCLK first goes high; the word is
                // published the cycle after its 16th rising edge.
                if (at_rise) begin
                    rx_d = {rx_q[14:0], miso};
                    if (bit_q == 5'd15) begin
                        rd_data_d  = {rx_q[14:0], miso};
                        rd_valid_d = 1'b1;
                    end
                end
                if (bit_end) begin
                    bit_d = bit_q + 5'd1;
                    if (bit_q == 5'd15) begin
                        bit_d   = '0;
                        words_d = words_q - 9'd1;
                        state_d = (words_q == 9'd1) ? CS_HOLD : RD_GAP;
                    end
                end
            end
            CS_HOLD: begin
                // First CLK_DIV cycles keep cs_n low, then CS_IDLE cycles high.
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        sclk     = shifting && (cnt_q >= HALF);
        mosi     = ((state_q == CS_SETUP) || (state_q == HEADER) || (state_q == WR_SHIFT))
                   ? shift_q[23] : 1'b0;
        cs_n     = (state_q == IDLE) || ((state_q == CS_HOLD) && (cnt_q >= HALF));
        busy     = (state_q != IDLE);
        wr_ready = (state_q == WR_WAIT) && wr_valid;
        rd_data  = rd_data_q;
        rd_valid = rd_valid_q;
        done     = done_q;
        cmd_err  = cmd_err_q;
    end

endmodule
